// File: rtl/eb_rd_ptr_ctrl.sv
// eb_rd_ptr_ctrl: read-side pointer controller for the PCS RX elastic buffer.
// Decodes the synchronized gray write pointer, tracks fill level, and keeps
// the buffer near half full by dropping or repeating SKP symbols.
// Optional build macro: EB_STATS_EN adds saturating SKP add/drop counters.
module eb_rd_ptr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int HALF_LEVEL = 8,
  parameter int MARGIN     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
  input  logic                  rd_en,
  input  logic                  skp_rd,
  output logic [ADDR_WIDTH:0]   rd_ptr_bin,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  underflow,
  output logic                  skp_delete,
  output logic                  skp_insert
`ifdef EB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [15:0]           skp_del_cnt,
  output logic [15:0]           skp_ins_cnt
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] HALF_TH = PW'(HALF_LEVEL);
  localparam logic [PW-1:0] DEL_TH  = PW'(HALF_LEVEL + MARGIN);
  localparam logic [PW-1:0] INS_TH  = PW'(HALF_LEVEL - MARGIN);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] ptr_nx;
  logic          uf_nx, del_nx, ins_nx;

  // Gray-to-binary decode of the synchronized write pointer.
  always_comb begin
    wr_bin         = '0;
    wr_bin[PW-1]   = wr_ptr_gray_sync[PW-1];
    for (int unsigned i = PW - 1; i > 0; i--)
      wr_bin[i-1] = wr_bin[i] ^ wr_ptr_gray_sync[i-1];
  end

  assign rd_addr    = rd_ptr_bin[ADDR_WIDTH-1:0];
  assign empty      = (fill_level == '0);
  assign data_valid = (state == RUN) && !empty;

  // Next-state, pointer action and pulse decisions from the registered fill.
  always_comb begin
    state_nx = state;
    ptr_nx   = rd_ptr_bin;
    uf_nx    = 1'b0;
    del_nx   = 1'b0;
    ins_nx   = 1'b0;
    case (state)
      FILL: begin
        if (fill_level >= HALF_TH)
          state_nx = RUN;
      end
      RUN: begin
        if (rd_en) begin
          if (empty) begin
            uf_nx    = 1'b1;
            state_nx = FILL;
          end else if (skp_rd && (fill_level > DEL_TH)) begin
            ptr_nx = rd_ptr_bin + PW'(2);
            del_nx = 1'b1;
          end else if (skp_rd && (fill_level < INS_TH)) begin
            ins_nx = 1'b1;
          end else begin
            ptr_nx = rd_ptr_bin + PW'(1);
          end
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // State, pointer, fill level and one-cycle pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      rd_ptr_bin <= '0;
      fill_level <= '0;
      underflow  <= 1'b0;
      skp_delete <= 1'b0;
      skp_insert <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_ptr_bin <= ptr_nx;
      fill_level <= wr_bin - rd_ptr_bin;
      underflow  <= uf_nx;
      skp_delete <= del_nx;
      skp_insert <= ins_nx;
    end
  end

`ifdef EB_STATS_EN
  // Saturating SKP drop/repeat counters; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skp_del_cnt <= '0;
      skp_ins_cnt <= '0;
    end else if (stats_clr) begin
      skp_del_cnt <= '0;
      skp_ins_cnt <= '0;
    end else begin
      if (skp_delete && (skp_del_cnt != '1))
        skp_del_cnt <= skp_del_cnt + 16'd1;
      if (skp_insert && (skp_ins_cnt != '1))
        skp_ins_cnt <= skp_ins_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eb_rd_ptr_ctrl.sv
// Testbench for eb_rd_ptr_ctrl: directed table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_eb_rd_ptr_ctrl;

  localparam int AW   = 4;
  localparam int PW   = AW + 1;
  localparam int PM   = 1 << PW;
  localparam int HALF = 8;
  localparam int MARG = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] gray;
  logic          rd_en, skp_rd;
  logic [PW-1:0] rd_ptr_bin, fill_level;
  logic [AW-1:0] rd_addr;
  logic          data_valid, empty, underflow, skp_delete, skp_insert;
`ifdef EB_STATS_EN
  logic          stats_clr;
  logic [15:0]   skp_del_cnt, skp_ins_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model state (plain integers)
  int m_ptr, m_fill, wr_b;
  bit m_run, m_uf, m_del, m_ins;
`ifdef EB_STATS_EN
  int m_dcnt, m_icnt;
`endif

  eb_rd_ptr_ctrl #(.ADDR_WIDTH(AW), .HALF_LEVEL(HALF), .MARGIN(MARG)) dut (
    .clk(clk), .rst(rst), .wr_ptr_gray_sync(gray), .rd_en(rd_en), .skp_rd(skp_rd),
    .rd_ptr_bin(rd_ptr_bin), .rd_addr(rd_addr), .fill_level(fill_level),
    .data_valid(data_valid), .empty(empty), .underflow(underflow),
    .skp_delete(skp_delete), .skp_insert(skp_insert)
`ifdef EB_STATS_EN
    , .stats_clr(stats_clr), .skp_del_cnt(skp_del_cnt), .skp_ins_cnt(skp_ins_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int wr; int rd; int skp;
    int ptr; int fill; int dv; int del; int ins; int uf;
  } vec_t;

  vec_t tbl[30];

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_fill = 0; m_run = 0; m_uf = 0; m_del = 0; m_ins = 0;
`ifdef EB_STATS_EN
    m_dcnt = 0; m_icnt = 0;
`endif
  endtask

  // One read-clock edge of the spec'd behaviour, using pre-edge values.
  task automatic model_edge(input bit rd, input bit skp);
    int nf;
`ifdef EB_STATS_EN
    if (stats_clr) begin
      m_dcnt = 0; m_icnt = 0;
    end else begin
      if (m_del && m_dcnt < 65535) m_dcnt++;
      if (m_ins && m_icnt < 65535) m_icnt++;
    end
`endif
    nf = ((wr_b - m_ptr) % PM + PM) % PM;
    m_uf = 0; m_del = 0; m_ins = 0;
    if (!m_run) begin
      if (m_fill >= HALF) m_run = 1;
    end else if (rd) begin
      if (m_fill == 0) begin
        m_uf = 1; m_run = 0;
      end else if (skp && m_fill > HALF + MARG) begin
        m_ptr = (m_ptr + 2) % PM; m_del = 1;
      end else if (skp && m_fill < HALF - MARG) begin
        m_ins = 1;
      end else begin
        m_ptr = (m_ptr + 1) % PM;
      end
    end
    m_fill = nf;
  endtask

  task automatic check_model(input string name);
    logic [63:0] act, exp;
    act = {rd_ptr_bin, rd_addr, fill_level, data_valid, empty, underflow, skp_delete, skp_insert};
    exp = {PW'(m_ptr), AW'(m_ptr), PW'(m_fill), 1'(m_run && m_fill != 0), 1'(m_fill == 0),
           m_uf, m_del, m_ins};
    check(name, act, exp);
`ifdef EB_STATS_EN
    check({name, "_cnt"}, {skp_del_cnt, skp_ins_cnt}, {16'(m_dcnt), 16'(m_icnt)});
`endif
  endtask

  task automatic step(input int wr, input bit rd, input bit skp);
    wr_b   = ((wr % PM) + PM) % PM;
    gray   = to_gray(wr_b);
    rd_en  = rd;
    skp_rd = skp;
    @(posedge clk);
    model_edge(rd, skp);
    #1;
    check_model("model");
  endtask

  initial begin
    tbl = '{
      '{0,1,0, 0,0,0,0,0,0}, '{1,1,0, 0,1,0,0,0,0}, '{2,1,0, 0,2,0,0,0,0},
      '{3,1,0, 0,3,0,0,0,0}, '{4,1,0, 0,4,0,0,0,0}, '{5,1,0, 0,5,0,0,0,0},
      '{6,1,0, 0,6,0,0,0,0}, '{7,1,0, 0,7,0,0,0,0}, '{8,1,0, 0,8,0,0,0,0},
      '{8,1,0, 0,8,1,0,0,0}, '{8,1,0, 1,8,1,0,0,0}, '{9,1,0, 2,8,1,0,0,0},
      '{10,1,0, 3,8,1,0,0,0}, '{14,0,0, 3,11,1,0,0,0}, '{14,1,1, 5,11,1,1,0,0},
      '{14,0,0, 5,9,1,0,0,0}, '{14,1,0, 6,9,1,0,0,0}, '{14,1,0, 7,8,1,0,0,0},
      '{14,1,0, 8,7,1,0,0,0}, '{14,1,0, 9,6,1,0,0,0}, '{14,0,0, 9,5,1,0,0,0},
      '{14,1,1, 9,5,1,0,1,0}, '{14,1,1, 9,5,1,0,1,0}, '{14,0,0, 9,5,1,0,0,0},
      '{15,0,0, 9,6,1,0,0,0}, '{15,1,1, 10,6,1,0,0,0}, '{15,0,0, 10,5,1,0,0,0},
      '{20,0,0, 10,10,1,0,0,0}, '{20,1,1, 11,10,1,0,0,0}, '{20,0,0, 11,9,1,0,0,0}
    };

    rst = 1'b1; gray = '0; rd_en = 1'b0; skp_rd = 1'b0; wr_b = 0;
`ifdef EB_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    #2;
    check("reset", {rd_ptr_bin, fill_level, data_valid, empty, underflow, skp_delete, skp_insert},
          {5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    #10 rst = 1'b0;

    // directed table: initial fill, delete, insert, no-action band
    for (int i = 0; i < 30; i++) begin
      step(tbl[i].wr, tbl[i].rd != 0, tbl[i].skp != 0);
      check($sformatf("tbl%0d", i),
            {rd_ptr_bin, fill_level, data_valid, skp_delete, skp_insert, underflow},
            {PW'(tbl[i].ptr), PW'(tbl[i].fill), 1'(tbl[i].dv), 1'(tbl[i].del),
             1'(tbl[i].ins), 1'(tbl[i].uf)});
    end

    // underflow: drain with read/idle pairs, then read while empty
    begin
      int p;
      for (int i = 0; i < 40 && m_fill != 0; i++) begin
        step(20, 1'b1, 1'b0);
        step(20, 1'b0, 1'b0);
      end
      check("drained", {fill_level, data_valid}, {5'd0, 1'b0});
      p = m_ptr;
      step(20, 1'b1, 1'b0);
      check("underflow", {underflow, data_valid, rd_ptr_bin}, {1'b1, 1'b0, PW'(p)});
      step(p + 4, 1'b1, 1'b0);
      check("uf_fill_hold", {underflow, data_valid, rd_ptr_bin}, {1'b0, 1'b0, PW'(p)});
      step(p + 8, 1'b0, 1'b0);
      step(p + 8, 1'b0, 1'b0);
      check("refill_run", {data_valid, fill_level, rd_ptr_bin}, {1'b1, 5'd8, PW'(p)});
    end

    // wrap: advance to pointer 31, then read with write pointer at 3
    for (int i = 0; i < 80 && m_ptr != PM - 1; i++) step(m_ptr + 8, 1'b1, 1'b0);
    check("at31", rd_ptr_bin, 5'd31);
    step(3, 1'b0, 1'b0);
    check("wrap_fill", fill_level, 5'd4);
    step(3, 1'b1, 1'b0);
    check("wrap_ptr", {rd_ptr_bin, rd_addr}, {5'd0, 4'd0});

    // asynchronous reset mid-RUN at pointer 13
    for (int i = 0; i < 80 && m_ptr != 13; i++) step(m_ptr + 8, 1'b1, 1'b0);
    check("at13", {rd_ptr_bin, data_valid}, {5'd13, 1'b1});
    #2 rst = 1'b1;
    #1;
    check("async_rst", {rd_ptr_bin, fill_level, data_valid, empty, underflow, skp_delete, skp_insert},
          {5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    model_reset();
`ifdef EB_STATS_EN
    check("rst_cnt", {skp_del_cnt, skp_ins_cnt}, 32'd0);
`endif
    #2 rst = 1'b0;
    wr_b = 0;

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      int nw;
      bit rd, skp;
      nw = wr_b;
      if ((((wr_b - m_ptr) % PM + PM) % PM) < 14) begin
        if (((i / 60) % 2) == 0) begin
          if ($urandom_range(0, 2) != 0) nw = wr_b + 1;
        end else begin
          if ($urandom_range(0, 2) == 0) nw = wr_b + 1;
        end
      end
      rd  = ($urandom_range(0, 3) != 0);
      skp = ($urandom_range(0, 2) == 0);
`ifdef EB_STATS_EN
      stats_clr = ($urandom_range(0, 19) == 0);
`endif
      step(nw, rd, skp);
    end
`ifdef EB_STATS_EN
    stats_clr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
